// File: rtl/fp_mult_seq_ctrl.sv
// Sequential single-precision FP multiplier. The radix-2 Booth mantissa product takes one
// bit per cycle, then a single cycle normalises, rounds and packs the result.
module fp_mult_seq_ctrl #(
    parameter int unsigned MANT_W = 24,
    parameter int unsigned EXP_W  = 8,
    parameter int unsigned BIAS   = 127
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        overflow,
    output logic        underflow,
    output logic        busy
);
    localparam int unsigned FW    = MANT_W - 1;
    localparam int unsigned BW    = MANT_W + 1;
    localparam int unsigned AW    = 2 * BW;
    localparam int unsigned PW    = 2 * MANT_W;
    localparam int unsigned XW    = EXP_W + 2;
    localparam int unsigned CNT_W = $clog2(BW);

    localparam logic [XW-1:0] BIAS_X  = XW'(BIAS);
    localparam logic [XW-1:0] EXP_MAX = XW'((1 << EXP_W) - 1);

    typedef enum logic [1:0] {StIdle, StMul, StRound, StDone} state_t;

    state_t            state_q, state_d;
    logic              sign_q, sign_d;
    logic [EXP_W-1:0]  exp_a_q, exp_a_d, exp_b_q, exp_b_d;
    logic [BW-1:0]     mcand_q, mcand_d;
    logic [AW-1:0]     acc_q, acc_d;
    logic              qm1_q, qm1_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       result_q, result_d;
    logic              ovf_q, ovf_d, unf_q, unf_d;

    logic              a_zero, b_zero;
    logic [BW-1:0]     upper;
    logic [AW-1:0]     booth_next;
    logic [PW-1:0]     prod;
    logic              norm, sticky, rc;
    logic [FW-1:0]     frac, frac_r;
    logic [FW:0]       frac_sum;
    logic [XW-1:0]     exp_x;
    logic              exp_ovf, exp_unf;

    assign a_zero = (a[30:0] == 31'b0);
    assign b_zero = (b[30:0] == 31'b0);

    // Booth step: add/subtract the multiplicand into the upper half, then arithmetic shift.
    always_comb begin
        upper = acc_q[AW-1:BW];
        case ({acc_q[0], qm1_q})
            2'b10:   upper = acc_q[AW-1:BW] - mcand_q;
            2'b01:   upper = acc_q[AW-1:BW] + mcand_q;
            default: upper = acc_q[AW-1:BW];
        endcase
        booth_next = {upper[BW-1], upper, acc_q[BW-1:1]};
    end

    always_comb begin
        prod     = acc_q[PW-1:0];
        norm     = prod[PW-1];
        frac     = norm ? prod[PW-2 -: FW] : prod[PW-3 -: FW];
        sticky   = norm ? |prod[MANT_W-1:0] : |prod[MANT_W-2:0];
        frac_sum = {1'b0, frac} + {{FW{1'b0}}, sticky};
        rc       = frac_sum[FW];
        // On carry-out the low bits are already zero.
        frac_r   = frac_sum[FW-1:0];
        exp_x    = {2'b00, exp_a_q} + {2'b00, exp_b_q} - BIAS_X
                 + {{(XW-1){1'b0}}, norm} + {{(XW-1){1'b0}}, rc};
        exp_ovf  = $signed(exp_x) >= $signed(EXP_MAX);
        exp_unf  = $signed(exp_x) < $signed(XW'(1));
    end

    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        exp_a_d  = exp_a_q;
        exp_b_d  = exp_b_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        qm1_d    = qm1_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    sign_d = a[31] ^ b[31];
                    ovf_d  = 1'b0;
                    unf_d  = 1'b0;
                    if (a_zero || b_zero) begin
                        result_d = {a[31] ^ b[31], 31'b0};
                        state_d  = StDone;
                    end else begin
                        exp_a_d = a[FW +: EXP_W];
                        exp_b_d = b[FW +: EXP_W];
                        mcand_d = {1'b0, |b[FW +: EXP_W], b[FW-1:0]};
                        acc_d   = {{BW{1'b0}}, 1'b0, |a[FW +: EXP_W], a[FW-1:0]};
                        qm1_d   = 1'b0;
                        cnt_d   = '0;
                        state_d = StMul;
                    end
                end
            end
            StMul: begin
                acc_d = booth_next;
                qm1_d = acc_q[0];
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(BW - 1)) begin
                    state_d = StRound;
                end
            end
            StRound: begin
                if (exp_ovf) begin
                    ovf_d    = 1'b1;
                    result_d = {sign_q, {EXP_W{1'b1}}, {FW{1'b0}}};
                end else if (exp_unf) begin
                    unf_d    = 1'b1;
                    result_d = {sign_q, {(EXP_W + FW){1'b0}}};
                end else begin
                    result_d = {sign_q, exp_x[EXP_W-1:0], frac_r};
                end
                state_d = StDone;
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            sign_q   <= 1'b0;
            exp_a_q  <= '0;
            exp_b_q  <= '0;
            mcand_q  <= '0;
            acc_q    <= '0;
            qm1_q    <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            exp_a_q  <= exp_a_d;
            exp_b_q  <= exp_b_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            qm1_q    <= qm1_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign out_valid = (state_q == StDone);
    assign result    = result_q;
    assign overflow  = ovf_q & out_valid;
    assign underflow = unf_q & out_valid;

endmodule

// File: tb/tb_fp_mult_seq_ctrl.sv
// Bench for fp_mult_seq_ctrl: directed vector table, randomized operands against a
// plain-arithmetic reference model, and backpressure / mid-operation reset sequences.
module tb_fp_mult_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        overflow;
    logic        underflow;
    logic        busy;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    fp_mult_seq_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .overflow  (overflow),
        .underflow (underflow),
        .busy      (busy)
    );

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ovf;
        logic        unf;
        int          lat;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Reference: exact 24x24 product, then the normalise/round/exponent rules directly.
    task automatic model(input logic [31:0] x, input logic [31:0] y, output logic [31:0] r,
                         output logic ovf, output logic unf, output int lat);
        longint unsigned mx, my, p, frac, sticky, fr;
        int              norm, rc, e;
        logic            s;
        s   = x[31] ^ y[31];
        ovf = 1'b0;
        unf = 1'b0;
        if (x[30:0] == 31'b0 || y[30:0] == 31'b0) begin
            r   = {s, 31'b0};
            lat = 1;
        end else begin
            mx   = {x[30:23] != 8'd0, x[22:0]};
            my   = {y[30:23] != 8'd0, y[22:0]};
            p    = mx * my;
            norm = int'(p >> 47);
            if (norm != 0) begin
                frac   = (p >> 24) & 64'h7F_FFFF;
                sticky = ((p & 64'hFF_FFFF) != 0) ? 1 : 0;
            end else begin
                frac   = (p >> 23) & 64'h7F_FFFF;
                sticky = ((p & 64'h7F_FFFF) != 0) ? 1 : 0;
            end
            fr  = frac + sticky;
            rc  = int'(fr >> 23);
            fr  = fr & 64'h7F_FFFF;
            e   = int'(x[30:23]) + int'(y[30:23]) - 127 + norm + rc;
            lat = 27;
            if (e >= 255) begin
                ovf = 1'b1;
                r   = {s, 8'hFF, 23'h0};
            end else if (e <= 0) begin
                unf = 1'b1;
                r   = {s, 31'h0};
            end else begin
                r = {s, e[7:0], fr[22:0]};
            end
        end
    endtask

    // Issue one operation, measure accept-to-out_valid latency, then take the result.
    task automatic run_op(input logic [31:0] x, input logic [31:0] y, output logic [31:0] r,
                          output logic ovf, output logic unf, output int lat);
        @(negedge clk);
        check("in_ready_idle", in_ready, 1);
        a         = x;
        b         = y;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        lat      = 1;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        r   = result;
        ovf = overflow;
        unf = underflow;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    logic [31:0] got_r, exp_r, x, y;
    logic        got_o, got_u, exp_o, exp_u;
    int          got_l, exp_l, wait_cnt;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_result", result, 0);
        check("rst_overflow", overflow, 0);
        check("rst_underflow", underflow, 0);

        vecs[0]  = '{"1.5x2.0",    32'h3FC00000, 32'h40000000, 32'h40400000, 0, 0, 27};
        vecs[1]  = '{"1.5x1.5",    32'h3FC00000, 32'h3FC00000, 32'h40100000, 0, 0, 27};
        vecs[2]  = '{"-1.5x2.0",   32'hBFC00000, 32'h40000000, 32'hC0400000, 0, 0, 27};
        vecs[3]  = '{"ovf",        32'h7F000000, 32'h7F000000, 32'h7F800000, 1, 0, 27};
        vecs[4]  = '{"ovf_neg",    32'hFF000000, 32'h7F000000, 32'hFF800000, 1, 0, 27};
        vecs[5]  = '{"unf",        32'h00800000, 32'h00800000, 32'h00000000, 0, 1, 27};
        vecs[6]  = '{"zero_a",     32'h00000000, 32'h40400000, 32'h00000000, 0, 0, 1};
        vecs[7]  = '{"negzero",    32'h80000000, 32'h3F800000, 32'h80000000, 0, 0, 1};
        vecs[8]  = '{"2x2",        32'h40000000, 32'h40000000, 32'h40800000, 0, 0, 27};
        vecs[9]  = '{"round_carry", 32'h3FB504F3, 32'h3FB504F3, 32'h40000000, 0, 0, 27};
        vecs[10] = '{"e_255",      32'h5F800000, 32'h5F800000, 32'h7F800000, 1, 0, 27};
        vecs[11] = '{"e_254",      32'h5F800000, 32'h5F000000, 32'h7F000000, 0, 0, 27};
        vecs[12] = '{"e_0",        32'h1F800000, 32'h20000000, 32'h00000000, 0, 1, 27};
        vecs[13] = '{"e_1",        32'h1F800000, 32'h20800000, 32'h00800000, 0, 0, 27};
        vecs[14] = '{"sticky",     32'h3FFFFFFF, 32'h3F800001, 32'h40000001, 0, 0, 27};

        for (int i = 0; i < 15; i++) begin
            run_op(vecs[i].a, vecs[i].b, got_r, got_o, got_u, got_l);
            check({vecs[i].name, "_result"}, got_r, vecs[i].res);
            check({vecs[i].name, "_ovf"}, got_o, vecs[i].ovf);
            check({vecs[i].name, "_unf"}, got_u, vecs[i].unf);
            check({vecs[i].name, "_latency"}, got_l, vecs[i].lat);
        end

        for (int i = 0; i < 40; i++) begin
            x = $urandom;
            y = $urandom;
            if (i % 2 == 0) begin
                x[30:23] = 8'(96 + $urandom_range(0, 63));
                y[30:23] = 8'(96 + $urandom_range(0, 63));
            end
            if (i % 10 == 7) y[30:0] = '0;
            model(x, y, exp_r, exp_o, exp_u, exp_l);
            run_op(x, y, got_r, got_o, got_u, got_l);
            check("rand_result", got_r, exp_r);
            check("rand_ovf", got_o, exp_o);
            check("rand_unf", got_u, exp_u);
            check("rand_latency", got_l, exp_l);
        end

        // Backpressure: in_valid stays high with other operands while busy and stalled.
        @(negedge clk);
        a        = 32'h3FC00000;
        b        = 32'h40000000;
        in_valid = 1'b1;
        @(negedge clk);
        a        = 32'h40000000;
        b        = 32'h40000000;
        wait_cnt = 1;
        while (!out_valid && wait_cnt < 100) begin
            @(negedge clk);
            wait_cnt++;
        end
        check("bp_latency", wait_cnt, 27);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_result_stable", result, 32'h40400000);
            check("bp_out_valid_held", out_valid, 1);
            check("bp_in_ready_low", in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("bp_out_valid_drop", out_valid, 0);
        check("bp_in_ready_back", in_ready, 1);
        check("bp_flags_low", {overflow, underflow}, 0);

        // Reset while the Booth loop is running.
        @(negedge clk);
        a        = 32'h40400000;
        b        = 32'h40400000;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("mid_busy", busy, 1);
        repeat (12) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_in_ready", in_ready, 1);
        run_op(32'h40000000, 32'h40000000, got_r, got_o, got_u, got_l);
        check("post_rst_result", got_r, 32'h40800000);
        check("post_rst_latency", got_l, 27);
        check("post_rst_flags", {got_o, got_u}, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
